// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, XLEN+2 cycle latency
//   clk, reset        : clock, synchronous active-high reset
//   start, funct3     : request and operation select (sampled while busy=0)
//   rs1_data, rs2_data: operands from the register file
//   busy, done        : operation in flight, single-cycle completion pulse
//   result            : registered result, held until the next done
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t              state, state_next;
    logic [2:0]          op;
    logic [XLEN-1:0]     a_reg, b_reg;
    logic [XLEN-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic                neg_a, neg_b;
    logic [CW-1:0]       count;

    logic                a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff, div_rem;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot, rem, fix_result;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = PREP;
            PREP: state_next = CALC;
            CALC: if (count == LAST) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand signedness: MULH/DIV/REM both, MULHSU rs1 only, MUL needs none
    // since the low product word is identical for any signedness.
    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sign_a   = a_signed & a_reg[XLEN-1];
        sign_b   = b_signed & b_reg[XLEN-1];
        abs_a    = sign_a ? -a_reg : a_reg;
        abs_b    = sign_b ? -b_reg : b_reg;
    end

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
    end

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits; the quotient bit enters at the bottom.
    always_comb begin
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[XLEN-1:0] - opnd;
        div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc[XLEN-2:0], div_ge};
    end

    // Divide by zero falls out of the magnitude datapath in the wrong sign,
    // so it is overridden here; signed overflow needs no special handling.
    always_comb begin
        prod_fix   = (neg_a ^ neg_b) ? -acc : acc;
        quot       = acc[XLEN-1:0];
        rem        = acc[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op)
            3'd0:                   fix_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       fix_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:             fix_result = (b_reg == '0) ? '1 :
                                                 ((neg_a ^ neg_b) ? -quot : quot);
            default:                fix_result = (b_reg == '0) ? a_reg :
                                                 (neg_a ? -rem : rem);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op     <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            count  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: if (start) begin
                    op    <= funct3;
                    a_reg <= rs1_data;
                    b_reg <= rs2_data;
                end
                PREP: begin
                    neg_a <= sign_a;
                    neg_b <= sign_b;
                    acc   <= {{XLEN{1'b0}}, op[2] ? abs_a : abs_b};
                    opnd  <= op[2] ? abs_b : abs_a;
                    count <= '0;
                end
                CALC: begin
                    acc   <= op[2] ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIX: result <= fix_result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Called #1 after the accepting edge; returns edges until done is seen.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
        int lat;
        bit bok;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        wait_done(lat, bok);
        check({nm, " latency"}, lat, 34);
        check({nm, " busy"}, {31'd0, bok}, 1);
        check({nm, " result"}, result, exp);
        check({nm, " busy_at_done"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int lat;
        bit bok;
        bit saw_done;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[9]  = '{3'd7, 32'd5,        32'd0,        32'd5};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        vecs[12] = '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
        vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        vecs[14] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[15] = '{3'd0, 32'h12345678, 32'h10,       32'h23456780};
        vecs[16] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1};
        vecs[17] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset result", result, 0);

        for (int i = 0; i < 18; i++)
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bok);
        check("ignore latency", lat, 34 - 10);
        check("ignore result", result, 32'd14);

        // start accepted in the done cycle
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b done_drop", {31'd0, done}, 0);
        check("b2b busy_rise", {31'd0, busy}, 1);
        wait_done(lat, bok);
        check("b2b latency", lat, 34);
        check("b2b busy", {31'd0, bok}, 1);
        check("b2b result", result, 32'd12);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset busy", {31'd0, busy}, 0);
        check("midreset done", {31'd0, done}, 0);
        check("midreset result", result, 0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("midreset no_done", {31'd0, saw_done}, 0);
        do_op(3'd0, 32'd2, 32'd3, 32'd6, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file.
- Consumes the two register-file read-data words plus funct3 from the multicycle controller.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN+2 cycles.
- Presents a registered result for the write-back path into the register file.
- The controller stalls in its execute state until done pulses.

Parameters:
XLEN, 32, operand/result width; latency = XLEN+2 clocks.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  one clock; reset is synchronous and active-high
start  input  1  request; sampled only while busy=0
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  input  XLEN  operand A (dividend / multiplicand), from register file readData1
rs2_data  input  XLEN  operand B (divisor / multiplier), from register file readData2
busy  output  1  high from the edge after start acceptance until the edge that raises done
done  output  1  single-cycle pulse; result valid
result  output  XLEN  registered result; holds value until next done

Behaviour:
- Reset (sampled high at an edge, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
  - Any in-flight operation is discarded; no done is produced for it.
- FSM states: IDLE, PREP, CALC, FIX.
  - IDLE: start=1 at edge E0 latches funct3, rs1_data and rs2_data; ->PREP; busy=1.
  - PREP, edge E1:
    - Compute operand sign flags per op: signed for MULH/DIV/REM, rs1 only for MULHSU, none otherwise.
    - Take absolute values; iteration count=0; ->CALC.
  - CALC, edges E2..E(XLEN+1): one iteration per edge.
    - Multiply: shift-add, 2*XLEN-bit product accumulator.
    - Divide: restoring, XLEN-bit remainder with XLEN-bit quotient.
    - At count=XLEN-1 ->FIX.
  - FIX, edge E(XLEN+2):
    - Apply sign correction and select the result word; result<=selected value.
    - done<=1, busy<=0; ->IDLE.
- Timing: done is high only in the cycle following edge E(XLEN+2), i.e. 34 clocks after start is sampled for XLEN=32.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - DIV/DIVU: quotient, truncated toward zero.
  - REM/REMU: remainder, with the sign of the dividend.
- Special cases, same latency with no early exit:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = rs1_data.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- start while busy=1 is ignored; operands are not re-latched.
- start in the same cycle done=1 is accepted: state is already IDLE. done then drops next cycle and busy rises.
- Operand inputs may change freely after E0; only the latched copies are used.
- rd=x0 filtering is not done here; the register file discards the x0 write.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 34 clocks after start; busy high for 34 cycles before it.
2. MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0, each at 34-clock latency.
5. Start DIVU 100/7, pulse start with new operands at cycle 10 -> ignored, result 14. Then assert start in the done cycle with MUL 3×4 -> accepted, result 12 after 34 further clocks.
6. Start DIV, assert reset at cycle 20 for one edge -> busy=0, done=0, result=0 next cycle; no done follows. A new MUL 2×3 then completes normally with 6.
